ccff_loader: RTL and testbench
==============================

CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 The module SHALL provide parameter CHAIN_LEN, default 88, giving the number of configuration flip-flops in the target chain (CHAIN_LEN >= 2).
REQ-002 The module SHALL provide parameter WORD_W, default 8, giving the bitstream word width (WORD_W >= 2).
REQ-003 The module SHALL have port prog_clk  input  1  the single clock; every flop is rising-edge.
REQ-004 The module SHALL have port prog_reset  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port start  input  1  one-cycle request to begin a pass.
REQ-006 The module SHALL have port verify  input  1  pass type, sampled with start: 0 = program, 1 = verify.
REQ-007 The module SHALL have ports s_valid  input  1 and s_data  input  WORD_W, forming the bitstream word source.
REQ-008 The module SHALL have port s_ready  output  1  word-accept handshake.
REQ-009 The module SHALL have ports ccff_head  output  1 (serial data to chain) and ccff_shift_en  output  1 (chain shift enable).
REQ-010 The module SHALL have port ccff_tail  input  1  serial data returning from the chain end.
REQ-011 The module SHALL have ports isol_n  output  1 (fabric I/O isolation, low = isolated), busy  output  1, done  output  1 (one-cycle pulse), mismatch  output  1 (sticky) and mismatch_cnt  output  16.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, SHIFT and FINISH.
REQ-013 In IDLE, start=1 SHALL latch verify, clear mismatch and mismatch_cnt, clear both bit counters, drive isol_n=0, and move to LOAD on the next edge; start in any other state SHALL be ignored.
REQ-014 s_ready SHALL be 1 only in LOAD; s_valid=1 in LOAD SHALL load s_data into the shift register and move to SHIFT.
REQ-015 In SHIFT, each cycle SHALL drive ccff_shift_en=1 and ccff_head=shift-register MSB, shift left by one, and increment the word-bit and total-bit counters.
REQ-016 Outside SHIFT, ccff_shift_en SHALL be 0 and ccff_head SHALL be 0.
REQ-017 Bits SHALL be sent MSB first; the first bit sent reaches the chain end after CHAIN_LEN shifts.
REQ-018 After the shift that makes the total equal CHAIN_LEN, the FSM SHALL go to FINISH, discarding the unsent low bits of the final word when CHAIN_LEN mod WORD_W != 0.
REQ-019 Otherwise, after WORD_W shifts of a word, the FSM SHALL return to LOAD.
REQ-020 A stall in LOAD (s_valid=0) SHALL hold all state with ccff_shift_en=0, so that no bit is lost or duplicated.
REQ-021 In a verify pass, each SHIFT cycle with ccff_tail != ccff_head SHALL set mismatch and increment mismatch_cnt, saturating at 16'hFFFF.
REQ-022 In a program pass, ccff_tail SHALL be ignored.
REQ-023 FINISH SHALL last one cycle, assert done=1, set isol_n=1, and return to IDLE.
REQ-024 busy SHALL be 1 in LOAD, SHIFT and FINISH, and 0 in IDLE.
REQ-025 mismatch and mismatch_cnt SHALL hold their values until the next accepted start.

Reset
REQ-026 While prog_reset=0 the module SHALL immediately force IDLE, all counters=0, shift register=0, s_ready=0, ccff_head=0, ccff_shift_en=0, isol_n=0, busy=0, done=0, mismatch=0 and mismatch_cnt=0.
REQ-027 Reset during a pass SHALL abandon the pass without a done pulse; chain contents are then undefined and isol_n SHALL remain 0 until a later pass completes.

Verification (CHAIN_LEN=20, WORD_W=8; the bench models the chain as a 20-flop shift register clocked when ccff_shift_en=1)
REQ-028 Program pass, words 8'hA5, 8'h3C, 8'hF0 -> exactly 20 shift cycles; ccff_head sequence 10100101 00111100 1111; done pulse; isol_n=1; model equals the sent bits.
REQ-029 Verify pass of the same three words after REQ-028 -> mismatch=0, mismatch_cnt=0, done pulse.
REQ-030 Verify pass with word 2 = 8'h3D -> mismatch=1, mismatch_cnt=1.
REQ-031 s_valid held low for 5 cycles before word 2 -> ccff_shift_en=0 and s_ready=1 throughout the stall; final chain contents identical to REQ-028.
REQ-032 prog_reset pulsed low after the 10th shift -> all outputs take their reset values asynchronously and no done pulse occurs; a following full program pass succeeds.
REQ-033 start pulsed while busy=1 -> ignored; the pass in progress completes unchanged, including the verify latched at its accepted start.

Source files
------------

// File: rtl/ccff_loader.sv
// Configuration flip-flop chain loader: streams bitstream words MSB first
// into a scan chain and optionally compares the returning tail bits.
module ccff_loader #(
  parameter int CHAIN_LEN = 88,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              isol_n,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [15:0]       mismatch_cnt
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam int TW = $clog2(CHAIN_LEN + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
  localparam logic [TW-1:0] TOT_LAST = TW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg_q;
  logic [BW-1:0]     bit_q;
  logic [TW-1:0]     tot_q;
  logic              verify_q;
  logic              isol_q;
  logic              mis_q;
  logic [15:0]       cnt_q;
  logic              idle_start;
  logic              mis_bit;

  assign idle_start    = (state_q == IDLE) && start;
  assign s_ready       = (state_q == LOAD);
  assign ccff_shift_en = (state_q == SHIFT);
  assign ccff_head     = ccff_shift_en && sreg_q[WORD_W-1];
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FINISH);
  // Isolation drops as soon as a pass is accepted, lifts in FINISH.
  assign isol_n        = done || (isol_q && !idle_start);
  assign mismatch      = mis_q;
  assign mismatch_cnt  = cnt_q;
  assign mis_bit       = ccff_shift_en && verify_q &&
                         (ccff_tail != sreg_q[WORD_W-1]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = LOAD;
      LOAD:   if (s_valid) state_d = SHIFT;
      SHIFT: begin
        if (tot_q == TOT_LAST)      state_d = FINISH;
        else if (bit_q == BIT_LAST) state_d = LOAD;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      bit_q    <= '0;
      tot_q    <= '0;
      verify_q <= 1'b0;
      isol_q   <= 1'b0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            verify_q <= verify;
            mis_q    <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= '0;
            tot_q    <= '0;
            isol_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (s_valid) begin
            sreg_q <= s_data;
            bit_q  <= '0;
          end
        end
        SHIFT: begin
          sreg_q <= sreg_q << 1;
          bit_q  <= bit_q + 1'b1;
          tot_q  <= tot_q + 1'b1;
          if (mis_bit) begin
            mis_q <= 1'b1;
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
          end
        end
        FINISH: isol_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: 20-flop chain model, head-bit scoreboard,
// program / verify / stall / reset / busy-start scenarios.
module tb_ccff_loader;

  localparam logic [19:0] GOLD = 20'hA53CF;

  logic        prog_clk = 1'b0;
  logic        prog_reset = 1'b1;
  logic        start = 1'b0;
  logic        verify = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        ccff_head;
  logic        ccff_shift_en;
  logic        ccff_tail;
  logic        isol_n;
  logic        busy;
  logic        done;
  logic        mismatch;
  logic [15:0] mismatch_cnt;

  logic [19:0] chain = '0;
  bit          exp_q[$];
  bit          eb;
  int          n_chk = 0;
  int          n_pass = 0;
  int          shift_cnt, done_cnt, isol_bad, stall_bad;

  ccff_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .start         (start),
    .verify        (verify),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .isol_n        (isol_n),
    .busy          (busy),
    .done          (done),
    .mismatch      (mismatch),
    .mismatch_cnt  (mismatch_cnt)
  );

  always #5 prog_clk = ~prog_clk;

  assign ccff_tail = chain[19];

  always @(posedge prog_clk)
    if (ccff_shift_en) chain <= {chain[18:0], ccff_head};

  always @(negedge prog_clk) begin
    if (prog_reset) begin
      if (ccff_shift_en) begin
        shift_cnt++;
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL head_extra: got shift %0d want none", shift_cnt);
        end else begin
          eb = exp_q.pop_front();
          if (ccff_head !== eb)
            $display("FAIL head_bit%0d: got %b want %b",
                     shift_cnt, ccff_head, eb);
          else n_pass++;
        end
      end
      if (done) done_cnt++;
      if ((ccff_shift_en || s_ready) && isol_n !== 1'b0) isol_bad++;
    end
  end

  task automatic run_pass(input bit v, input logic [7:0] w0,
                          input logic [7:0] w1, input logic [7:0] w2,
                          input int stall, input bit kill,
                          input bit poke);
    logic [7:0] w [3];
    int sent;
    bit ok;
    w[0] = w0;
    w[1] = w1;
    w[2] = w2;
    shift_cnt = 0;
    done_cnt = 0;
    isol_bad = 0;
    stall_bad = 0;
    sent = 0;
    for (int i = 0; i < 3; i++)
      for (int b = 7; b >= 0; b--)
        if (sent < 20) begin
          exp_q.push_back(w[i][b]);
          sent++;
        end
    @(posedge prog_clk); #1;
    start = 1'b1;
    verify = v;
    @(posedge prog_clk); #1;
    start = 1'b0;
    verify = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (kill && i == 2) begin
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
          @(negedge prog_clk); #1;
          ok = (shift_cnt >= 10);
        end
        if (!ok) begin
          n_chk++;
          $display("FAIL kill_timeout: got %0d shifts want 10", shift_cnt);
        end
        return;
      end
      ok = 1'b0;
      for (int k = 0; k < 60 && !ok; k++) begin
        @(negedge prog_clk); #1;
        ok = s_ready;
      end
      if (!ok) begin
        n_chk++;
        $display("FAIL ready_timeout: got s_ready=0 want 1 word %0d", i);
        return;
      end
      if (i == 1)
        for (int j = 0; j < stall; j++) begin
          if (!(s_ready === 1'b1 && ccff_shift_en === 1'b0)) stall_bad++;
          if (j < stall - 1) begin
            @(negedge prog_clk); #1;
          end
        end
      s_data = w[i];
      s_valid = 1'b1;
      @(posedge prog_clk); #1;
      s_valid = 1'b0;
      if (poke && i == 0) begin
        @(negedge prog_clk); #1;
        start = 1'b1;
        verify = !v;
        @(posedge prog_clk); #1;
        start = 1'b0;
        verify = 1'b0;
      end
    end
    ok = 1'b0;
    for (int k = 0; k < 80 && !ok; k++) begin
      @(negedge prog_clk); #1;
      ok = !busy;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL done_timeout: got busy=1 want 0");
    end
  endtask

  task automatic test_reset();
    logic [22:0] o;
    #1 prog_reset = 1'b0;
    #2;
    o = {s_ready, ccff_head, ccff_shift_en, isol_n, busy, done,
         mismatch, mismatch_cnt};
    n_chk++;
    if (o !== '0) $display("FAIL reset_outputs: got %h want 0", o);
    else n_pass++;
    repeat (2) @(posedge prog_clk);
    @(negedge prog_clk);
    prog_reset = 1'b1;
  endtask

  task automatic test_program();
    run_pass(1'b0, 8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 1'b0);
    n_chk++;
    if (shift_cnt !== 20) $display("FAIL prog_shifts: got %0d want 20", shift_cnt);
    else n_pass++;
    n_chk++;
    if (done_cnt !== 1) $display("FAIL prog_done: got %0d want 1", done_cnt);
    else n_pass++;
    n_chk++;
    if (isol_n !== 1'b1) $display("FAIL prog_isol: got %b want 1", isol_n);
    else n_pass++;
    n_chk++;
    if (isol_bad !== 0) $display("FAIL prog_isol_busy: got %0d want 0", isol_bad);
    else n_pass++;
    n_chk++;
    if (chain !== GOLD) $display("FAIL prog_chain: got %h want %h", chain, GOLD);
    else n_pass++;
    n_chk++;
    if (exp_q.size() !== 0) $display("FAIL prog_unsent: got %0d want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_verify_match();
    run_pass(1'b1, 8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 1'b0);
    n_chk++;
    if ({mismatch, mismatch_cnt} !== 17'd0)
      $display("FAIL vmatch_mis: got %b/%0d want 0/0", mismatch, mismatch_cnt);
    else n_pass++;
    n_chk++;
    if (done_cnt !== 1) $display("FAIL vmatch_done: got %0d want 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_verify_mismatch();
    run_pass(1'b1, 8'hA5, 8'h3D, 8'hF0, 0, 1'b0, 1'b0);
    n_chk++;
    if (mismatch !== 1'b1 || mismatch_cnt !== 16'd1)
      $display("FAIL vmis_cnt: got %b/%0d want 1/1", mismatch, mismatch_cnt);
    else n_pass++;
    repeat (5) @(negedge prog_clk);
    n_chk++;
    if (mismatch !== 1'b1 || mismatch_cnt !== 16'd1)
      $display("FAIL vmis_hold: got %b/%0d want 1/1", mismatch, mismatch_cnt);
    else n_pass++;
  endtask

  task automatic test_stall();
    run_pass(1'b0, 8'hA5, 8'h3C, 8'hF0, 5, 1'b0, 1'b0);
    n_chk++;
    if (stall_bad !== 0) $display("FAIL stall_hold: got %0d bad want 0", stall_bad);
    else n_pass++;
    n_chk++;
    if (shift_cnt !== 20) $display("FAIL stall_shifts: got %0d want 20", shift_cnt);
    else n_pass++;
    n_chk++;
    if (chain !== GOLD) $display("FAIL stall_chain: got %h want %h", chain, GOLD);
    else n_pass++;
  endtask

  task automatic test_reset_mid_pass();
    logic [22:0] o;
    run_pass(1'b1, 8'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0);
    @(posedge prog_clk); #2;
    n_chk++;
    if (mismatch_cnt !== 16'd4)
      $display("FAIL kill_precnt: got %0d want 4", mismatch_cnt);
    else n_pass++;
    #1 prog_reset = 1'b0;
    #1;
    o = {s_ready, ccff_head, ccff_shift_en, isol_n, busy, done,
         mismatch, mismatch_cnt};
    n_chk++;
    if (o !== '0) $display("FAIL kill_outputs: got %h want 0", o);
    else n_pass++;
    repeat (2) @(posedge prog_clk);
    @(negedge prog_clk);
    prog_reset = 1'b1;
    exp_q.delete();
    repeat (4) @(negedge prog_clk);
    n_chk++;
    if (done_cnt !== 0 || isol_n !== 1'b0)
      $display("FAIL kill_nodone: got done=%0d isol=%b want 0/0", done_cnt, isol_n);
    else n_pass++;
    run_pass(1'b0, 8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 1'b0);
    n_chk++;
    if (chain !== GOLD || done_cnt !== 1 || isol_n !== 1'b1)
      $display("FAIL kill_reprog: got %h/%0d/%b want %h/1/1",
               chain, done_cnt, isol_n, GOLD);
    else n_pass++;
  endtask

  task automatic test_busy_start();
    run_pass(1'b1, 8'hA5, 8'h3D, 8'hF0, 0, 1'b0, 1'b1);
    n_chk++;
    if (shift_cnt !== 20 || done_cnt !== 1)
      $display("FAIL busy_pass: got %0d shifts/%0d done want 20/1",
               shift_cnt, done_cnt);
    else n_pass++;
    n_chk++;
    if (mismatch !== 1'b1 || mismatch_cnt !== 16'd1)
      $display("FAIL busy_verify: got %b/%0d want 1/1", mismatch, mismatch_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_program();
    test_verify_match();
    test_verify_mismatch();
    test_stall();
    test_reset_mid_pass();
    test_busy_start();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
